// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencing for the five-stage RV32I pipeline.
// Resolves load-use hazards in ID, taken redirects from MEM and multi-cycle
// data-memory waits, with a watchdog that halts the core on a dead memory.
// Optional build macro: PIPE_PERF_CNT_EN adds saturating stall/flush counters;
// without it stall_cycles and flush_events are tied to zero.
module pipeline_ctrl #(
  parameter int REG_SEL     = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_SEL-1:0] id_rs1,
  input  logic [REG_SEL-1:0] id_rs2,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic [REG_SEL-1:0] ex_rd,
  input  logic               ex_mem_read,
  input  logic               pc_src,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               stall_pc,
  output logic               stall_ifid,
  output logic               stall_idex,
  output logic               stall_exmem,
  output logic               stall_memwb,
  output logic               flush_ifid,
  output logic               flush_idex,
  output logic               flush_exmem,
  output logic               flush_memwb,
  output logic               mem_fault,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_events
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALT
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              load_use;
  logic              do_wait;
  logic              do_redirect;
  logic              do_bubble;
  logic              do_halt;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Next-state and action selection; a completing wait falls through to the redirect/bubble checks
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    do_wait       = 1'b0;
    do_redirect   = 1'b0;
    do_bubble     = 1'b0;
    do_halt       = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          do_wait       = 1'b1;
          wait_cnt_next = WAIT_W'(1);
          state_next    = MEM_WAIT;
        end else if (pc_src) begin
          do_redirect = 1'b1;
        end else if (load_use) begin
          do_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_next = RUN;
          if (pc_src) begin
            do_redirect = 1'b1;
          end else if (load_use) begin
            do_bubble = 1'b1;
          end
        end else begin
          do_wait       = 1'b1;
          wait_cnt_next = wait_cnt + WAIT_W'(1);
          if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_next = HALT;
          end
        end
      end
      HALT: begin
        do_halt = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Map the selected action onto the per-register controls, all forced low while in reset
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    stall_memwb = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    if (!rst) begin
      stall_pc    = do_wait | do_bubble | do_halt;
      stall_ifid  = do_wait | do_bubble | do_halt;
      stall_idex  = do_wait | do_halt;
      stall_exmem = do_wait | do_halt;
      stall_memwb = do_halt;
      flush_ifid  = do_redirect;
      flush_idex  = do_redirect | do_bubble;
      flush_exmem = do_redirect;
      flush_memwb = do_wait | do_halt;
    end
  end

  // State, wait counter and sticky fault flag; the fault latches on the edge into HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      mem_fault <= mem_fault | (state_next == HALT);
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Saturating performance counters sampling the live stall_pc / flush_ifid controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_pc && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (flush_ifid && (flush_events != '1)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors for pipeline_ctrl. Each driven cycle
// pushes its expected controls into a queue; a monitor pops and compares on
// the falling edge. Honours PIPE_PERF_CNT_EN for the counter expectations.
module tb_pipeline_ctrl;

  // expected vector bit order: {stall_pc, stall_ifid, stall_idex, stall_exmem,
  // stall_memwb, flush_ifid, flush_idex, flush_exmem, flush_memwb, mem_fault}
  localparam logic [9:0] IDLE  = 10'b0000000000;
  localparam logic [9:0] LU    = 10'b1100001000;
  localparam logic [9:0] RED   = 10'b0000011100;
  localparam logic [9:0] WAITV = 10'b1111000010;
  localparam logic [9:0] HALTV = 10'b1111100011;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [9:0]  vec;
    logic [31:0] sc;
    logic [31:0] fe;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        pc_src;
  logic        mem_req;
  logic        mem_ready;
  logic        stall_pc;
  logic        stall_ifid;
  logic        stall_idex;
  logic        stall_exmem;
  logic        stall_memwb;
  logic        flush_ifid;
  logic        flush_idex;
  logic        flush_exmem;
  logic        flush_memwb;
  logic        mem_fault;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  exp_t        sb[$];
  int          total;
  int          bad;
  int unsigned exp_sc;
  int unsigned exp_fe;

  pipeline_ctrl #(.REG_SEL(5), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read),
    .pc_src(pc_src),
    .mem_req(mem_req),
    .mem_ready(mem_ready),
    .stall_pc(stall_pc),
    .stall_ifid(stall_ifid),
    .stall_idex(stall_idex),
    .stall_exmem(stall_exmem),
    .stall_memwb(stall_memwb),
    .flush_ifid(flush_ifid),
    .flush_idex(flush_idex),
    .flush_exmem(flush_exmem),
    .flush_memwb(flush_memwb),
    .mem_fault(mem_fault),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one cycle of inputs, queue its expectation, then step past the next rising edge
  task automatic applyStimulus(input string name, input logic r,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2,
                               input logic [4:0] rd, input logic mr,
                               input logic pcs, input logic mreq,
                               input logic mrdy, input logic [9:0] exp_vec);
    exp_t e;
    rst         = r;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    ex_rd       = rd;
    ex_mem_read = mr;
    pc_src      = pcs;
    mem_req     = mreq;
    mem_ready   = mrdy;
    if (r) begin
      exp_sc = 0;
      exp_fe = 0;
    end
    e.name = name;
    e.vec  = exp_vec;
    e.sc   = PERF ? exp_sc : 32'd0;
    e.fe   = PERF ? exp_fe : 32'd0;
    sb.push_back(e);
    if (!r && exp_vec[9]) exp_sc++;
    if (!r && exp_vec[4]) exp_fe++;
    @(posedge clk);
    #1;
  endtask

  // compare the live controls and counters against one queued expectation
  task automatic checkOutput(input exp_t e);
    logic [9:0] act;
    act = {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
           flush_ifid, flush_idex, flush_exmem, flush_memwb, mem_fault};
    total++;
    if (act !== e.vec) begin
      bad++;
      $display("[TB] FAIL %s ctrl got=%b want=%b", e.name, act, e.vec);
    end
    total++;
    if (stall_cycles !== e.sc || flush_events !== e.fe) begin
      bad++;
      $display("[TB] FAIL %s counters got=%0d/%0d want=%0d/%0d", e.name,
               stall_cycles, flush_events, e.sc, e.fe);
    end
  endtask

  // monitor: whenever an expectation is pending, check it mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  initial begin
    total = 0; bad = 0; exp_sc = 0; exp_fe = 0;
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = '0; ex_mem_read = 1'b0; pc_src = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset forces outputs low even with a redirect and hazard present
    applyStimulus("reset_held", 1, 0, 5, 0, 1, 5, 1, 1, 0, 0, IDLE);
    applyStimulus("after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);

    // load-use hazards
    applyStimulus("lu_rs2", 0, 0, 5, 0, 1, 5, 1, 0, 0, 0, LU);
    applyStimulus("lu_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
    applyStimulus("lu_rs1", 0, 7, 0, 1, 0, 7, 1, 0, 0, 0, LU);
    applyStimulus("lu_rs1_unused", 0, 7, 0, 0, 0, 7, 1, 0, 0, 0, IDLE);
    applyStimulus("lu_not_load", 0, 0, 5, 0, 1, 5, 0, 0, 0, 0, IDLE);
    applyStimulus("lu_rd_zero", 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, IDLE);

    // redirect beats a concurrent hazard; ready without request is ignored
    applyStimulus("redirect_over_lu", 0, 0, 5, 0, 1, 5, 1, 1, 0, 0, RED);
    applyStimulus("ready_no_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, IDLE);

    // three-cycle memory wait, entry cycle ignores pc_src
    applyStimulus("wait_entry", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, WAITV);
    applyStimulus("wait_2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, WAITV);
    applyStimulus("wait_3", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, WAITV);
    applyStimulus("wait_done", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, IDLE);
    applyStimulus("wait_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);

    // completion cycle honours a redirect, or a load-use hazard
    applyStimulus("wr_entry", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, WAITV);
    applyStimulus("wr_done_redirect", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, RED);
    applyStimulus("wl_entry", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, WAITV);
    applyStimulus("wl_done_lu", 0, 3, 0, 1, 0, 3, 1, 0, 1, 1, LU);
    applyStimulus("wl_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);

    // longest tolerated wait: 15 low cycles then ready stays out of HALT
    for (int i = 0; i < 15; i++)
      applyStimulus("wait15", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, WAITV);
    applyStimulus("wait15_done", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, IDLE);

    // watchdog: 16 low cycles lands in HALT, which ignores everything but reset
    for (int i = 0; i < 16; i++)
      applyStimulus("timeout_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, WAITV);
    applyStimulus("halt", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HALTV);
    applyStimulus("halt_ready", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, HALTV);
    applyStimulus("halt_redirect", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, HALTV);
    applyStimulus("halt_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
    applyStimulus("halt_cleared", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);

    // reset raised between edges while waiting clears outputs at once
    applyStimulus("ar_entry", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, WAITV);
    applyStimulus("ar_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, WAITV);
    applyStimulus("ar_async", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, IDLE);
    applyStimulus("ar_back_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
    applyStimulus("ar_redirect", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RED);
    applyStimulus("ar_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain pending=%0d want=0", sb.size());
    end
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
